csr_cmt_ctrl: RTL and testbench
===============================

CSR_CMT_CTRL -- requirements
Module: csr_cmt_ctrl

Interface
REQ-001 Clocking SHALL be one clock `clk`, and reset SHALL be `rst`, asynchronous and active-high.
REQ-002 Ports SHALL be (name  dir  width  meaning):
- clk  in  1  clock
- rst  in  1  async active-high reset
- req_valid  in  1  commit request from WB
- req_ready  out  1  request accepted
- req_op  in  3  0=CSRRD 1=CSRWR 2=CSRXCHG 3=ERTN 4=EXC
- req_csr_num  in  14  CSR number
- req_wdata  in  32  rd value to write
- req_mask  in  32  rj mask (XCHG)
- req_pc  in  32  instruction PC
- req_vaddr  in  32  faulting address
- req_ecode  in  8  exception code
- req_esubcode  in  1  exception subcode
- resp_valid  out  1  CSR op done
- resp_rdata  out  32  old CSR value for rd
- csr_re  out  1  CSR read enable
- csr_raddr  out  14  CSR read address
- csr_rdata  in  32  CSR read data (combinational)
- csr_we  out  1  CSR write enable
- csr_waddr  out  14  CSR write address
- csr_wmask  out  32  CSR write mask
- csr_wdata  out  32  CSR write data
- ex_en  out  1  exception commit pulse
- ecode  out  8  committed exception code
- esubcode  out  1  committed exception subcode
- pc  out  32  committed exception PC
- vaddr  out  32  committed bad vaddr
- ertn_flush  out  1  ERTN commit pulse
- has_int  in  1  pending enabled interrupt
- int_ecode  in  8  interrupt code (unused; INT = 0x00)
- ex_entryPC  in  32  EENTRY value
- new_pc  in  32  ERTN return target
- flush  out  1  pipeline flush pulse
- redirect_valid  out  1  fetch redirect pulse
- redirect_pc  out  32  fetch redirect target

Function
REQ-003 FSM states SHALL be IDLE, READ, WRITE, RESP, TRAP, RET, REDIR; req_ready SHALL be 1 only in IDLE with rst low.
REQ-004 In IDLE, acceptance SHALL occur when req_valid=1, latching every req_* field.
- has_int=1 at acceptance: the request is discarded → TRAP, ecode=0x00, esubcode=0, pc=req_pc.
- Otherwise dispatch: op 0–2 → READ, 3 → RET, 4 → TRAP.
REQ-005 READ SHALL assert csr_re=1 with csr_raddr=latched number and capture csr_rdata into resp_rdata. Then CSRRD → RESP; CSRWR/CSRXCHG → WRITE.
REQ-006 WRITE SHALL assert csr_we=1 for one cycle, then go to RESP.
- csr_waddr = latched number; csr_wdata = latched wdata.
- csr_wmask = 0xFFFFFFFF for CSRWR, latched mask for CSRXCHG.
REQ-007 RESP SHALL pulse resp_valid=1 for one cycle, then go to IDLE; resp_rdata SHALL hold until the next capture.
REQ-008 Latency from acceptance cycle T SHALL be: CSRRD resp_valid at T+2; CSRWR/CSRXCHG csr_we at T+2, resp_valid at T+3.
REQ-009 TRAP SHALL pulse ex_en=1 for one cycle with ecode/esubcode/pc/vaddr driven from latches. It SHALL sample ex_entryPC into redirect_pc, then go to REDIR.
REQ-010 RET SHALL pulse ertn_flush=1 for one cycle and sample new_pc in that same cycle into redirect_pc, then go to REDIR.
REQ-011 REDIR SHALL assert flush=1 and redirect_valid=1 for exactly one cycle, then go to IDLE.
REQ-012 Pulse exclusivity:
- csr_we, ex_en and ertn_flush SHALL never be high in the same cycle.
- csr_re SHALL be low outside READ.
- pc/vaddr/ecode SHALL be 0 when ex_en=0.
REQ-013 Unknown req_op (5–7) SHALL be accepted and treated as EXC with ecode=0x0D (INE), esubcode=0.

Reset
REQ-014 While rst=1, state SHALL be IDLE and every output SHALL be 0, including req_ready and resp_rdata.
REQ-015 Reset asserted mid-operation SHALL drop csr_we, ex_en and ertn_flush combinationally, with no later completion of the aborted request.

Configuration
REQ-016 With CSR_CMT_FASTRD_EN defined, CSRRD SHALL bypass READ:
- csr_re/csr_raddr are driven combinationally from req_csr_num during the IDLE acceptance cycle.
- csr_rdata is captured at that edge → RESP, so resp_valid arrives at T+1.
- CSRWR/CSRXCHG are unchanged.
REQ-017 Without CSR_CMT_FASTRD_EN, REQ-008 timing SHALL apply to all ops.

Structure
REQ-018 Shared items SHALL live in the shared defines package: op encodings, state encodings, and ECODE_INT/ECODE_INE constants.
REQ-019 The block SHALL be a single module with no sub-module; the FSM is too small to split.

Verification
REQ-020 The bench SHALL cover:
- CSRRD 0x30, csr_rdata=0xDEADBEEF → resp_valid at T+2, resp_rdata=0xDEADBEEF, csr_we never high.
- CSRXCHG 0x04, wdata=0x1FFF, mask=0x0800 → csr_we at T+2 with waddr=0x04, wmask=0x0800, wdata=0x1FFF; resp_valid at T+3.
- EXC ecode=0x09, vaddr=0x1003, pc=0x1C000100, ex_entryPC=0x1C008000 → ex_en one cycle with matching fields; next cycle redirect_pc=0x1C008000, flush=1.
- CSRWR with has_int=1 at acceptance → no csr_we; ex_en with ecode=0x00, pc=req_pc.
- ERTN, new_pc=0x1C000204 → ertn_flush one cycle, then redirect_valid=1, redirect_pc=0x1C000204.
- rst raised during WRITE → csr_we=0 immediately, req_ready=0 until rst drops, no resp_valid afterwards.

Source files
------------

// File: rtl/csr_cmt_ctrl_pkg.sv
// Shared encodings for the CSR commit controller: request ops, FSM states
// and the exception codes it raises on its own.
package csr_cmt_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_CSRRD   = 3'd0,
        OP_CSRWR   = 3'd1,
        OP_CSRXCHG = 3'd2,
        OP_ERTN    = 3'd3,
        OP_EXC     = 3'd4
    } cmt_op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WRITE = 3'd2,
        ST_RESP  = 3'd3,
        ST_TRAP  = 3'd4,
        ST_RET   = 3'd5,
        ST_REDIR = 3'd6
    } cmt_state_e;

    localparam logic [7:0] ECODE_INT = 8'h00;
    localparam logic [7:0] ECODE_INE = 8'h0D;

endpackage

// File: rtl/csr_cmt_ctrl.sv
// CSR commit controller: sequences CSR read/write, exception and ERTN commits.
// Optional CSR_CMT_FASTRD_EN: CSRRD reads the CSR file in the acceptance cycle.
module csr_cmt_ctrl
    import csr_cmt_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [13:0] req_csr_num,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_mask,
    input  logic [31:0] req_pc,
    input  logic [31:0] req_vaddr,
    input  logic [7:0]  req_ecode,
    input  logic        req_esubcode,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        csr_re,
    output logic [13:0] csr_raddr,
    input  logic [31:0] csr_rdata,
    output logic        csr_we,
    output logic [13:0] csr_waddr,
    output logic [31:0] csr_wmask,
    output logic [31:0] csr_wdata,
    output logic        ex_en,
    output logic [7:0]  ecode,
    output logic        esubcode,
    output logic [31:0] pc,
    output logic [31:0] vaddr,
    output logic        ertn_flush,
    input  logic        has_int,
    input  logic [7:0]  int_ecode,
    input  logic [31:0] ex_entryPC,
    input  logic [31:0] new_pc,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    cmt_state_e  state_q, state_d;
    logic [2:0]  op_q;
    logic [13:0] num_q;
    logic [31:0] wdata_q, mask_q, pc_q, vaddr_q;
    logic [7:0]  ecode_q;
    logic        esub_q;
    logic [31:0] rdata_q, redir_q;
    logic        accept, fast_rd;

    // Interrupt code is fixed to INT; the input is kept for port compatibility.
    logic unused_int_ecode;
    assign unused_int_ecode = ^int_ecode;

    assign accept = (state_q == ST_IDLE) && req_valid && !rst;

`ifdef CSR_CMT_FASTRD_EN
    assign fast_rd = accept && !has_int && (req_op == OP_CSRRD);
`else
    assign fast_rd = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        csr_re         = 1'b0;
        csr_raddr      = '0;
        csr_we         = 1'b0;
        csr_waddr      = '0;
        csr_wmask      = '0;
        csr_wdata      = '0;
        ex_en          = 1'b0;
        ecode          = '0;
        esubcode       = 1'b0;
        pc             = '0;
        vaddr          = '0;
        ertn_flush     = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                req_ready = !rst;
                if (fast_rd) begin
                    csr_re    = 1'b1;
                    csr_raddr = req_csr_num;
                    state_d   = ST_RESP;
                end else if (accept) begin
                    if (has_int)
                        state_d = ST_TRAP;
                    else if (req_op <= OP_CSRXCHG)
                        state_d = ST_READ;
                    else if (req_op == OP_ERTN)
                        state_d = ST_RET;
                    else
                        state_d = ST_TRAP;
                end
            end
            ST_READ: begin
                csr_re    = 1'b1;
                csr_raddr = num_q;
                state_d   = (op_q == OP_CSRRD) ? ST_RESP : ST_WRITE;
            end
            ST_WRITE: begin
                csr_we    = 1'b1;
                csr_waddr = num_q;
                csr_wdata = wdata_q;
                csr_wmask = (op_q == OP_CSRXCHG) ? mask_q : 32'hFFFF_FFFF;
                state_d   = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                state_d    = ST_IDLE;
            end
            ST_TRAP: begin
                ex_en    = 1'b1;
                ecode    = ecode_q;
                esubcode = esub_q;
                pc       = pc_q;
                vaddr    = vaddr_q;
                state_d  = ST_REDIR;
            end
            ST_RET: begin
                ertn_flush = 1'b1;
                state_d    = ST_REDIR;
            end
            ST_REDIR: begin
                flush          = 1'b1;
                redirect_valid = 1'b1;
                state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign resp_rdata  = rdata_q;
    assign redirect_pc = redir_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            num_q   <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            pc_q    <= '0;
            vaddr_q <= '0;
            ecode_q <= '0;
            esub_q  <= 1'b0;
            rdata_q <= '0;
            redir_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q    <= req_op;
                num_q   <= req_csr_num;
                wdata_q <= req_wdata;
                mask_q  <= req_mask;
                pc_q    <= req_pc;
                vaddr_q <= req_vaddr;
                // Interrupts and illegal ops override the requester's code.
                if (has_int) begin
                    ecode_q <= ECODE_INT;
                    esub_q  <= 1'b0;
                end else if (req_op > OP_EXC) begin
                    ecode_q <= ECODE_INE;
                    esub_q  <= 1'b0;
                end else begin
                    ecode_q <= req_ecode;
                    esub_q  <= req_esubcode;
                end
            end
            if (fast_rd || state_q == ST_READ)
                rdata_q <= csr_rdata;
            if (state_q == ST_TRAP)
                redir_q <= ex_entryPC;
            else if (state_q == ST_RET)
                redir_q <= new_pc;
        end
    end

endmodule

// File: tb/tb_csr_cmt_ctrl.sv
// Directed bench for csr_cmt_ctrl: CSR ops, traps, ERTN, interrupt
// override, illegal op and reset abort, with hand-computed expectations.
module tb_csr_cmt_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [13:0] req_csr_num;
    logic [31:0] req_wdata, req_mask, req_pc, req_vaddr;
    logic [7:0]  req_ecode;
    logic        req_esubcode;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        csr_re;
    logic [13:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic        csr_we;
    logic [13:0] csr_waddr;
    logic [31:0] csr_wmask, csr_wdata;
    logic        ex_en;
    logic [7:0]  ecode;
    logic        esubcode;
    logic [31:0] pc, vaddr;
    logic        ertn_flush;
    logic        has_int;
    logic [7:0]  int_ecode;
    logic [31:0] ex_entryPC, new_pc;
    logic        flush, redirect_valid;
    logic [31:0] redirect_pc;

    int checks = 0;
    int failures = 0;

    csr_cmt_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_csr_num(req_csr_num),
        .req_wdata(req_wdata), .req_mask(req_mask),
        .req_pc(req_pc), .req_vaddr(req_vaddr),
        .req_ecode(req_ecode), .req_esubcode(req_esubcode),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .csr_re(csr_re), .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
        .csr_we(csr_we), .csr_waddr(csr_waddr),
        .csr_wmask(csr_wmask), .csr_wdata(csr_wdata),
        .ex_en(ex_en), .ecode(ecode), .esubcode(esubcode),
        .pc(pc), .vaddr(vaddr), .ertn_flush(ertn_flush),
        .has_int(has_int), .int_ecode(int_ecode),
        .ex_entryPC(ex_entryPC), .new_pc(new_pc),
        .flush(flush), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for exactly one cycle (the acceptance cycle T).
    task automatic issue(input logic [2:0] op, input logic [13:0] num,
                         input logic [31:0] wd, input logic [31:0] mk);
        req_valid   = 1'b1;
        req_op      = op;
        req_csr_num = num;
        req_wdata   = wd;
        req_mask    = mk;
        chk("ready_at_T", {31'd0, req_ready}, 32'd1);
        step();
        req_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 0; req_op = 0; req_csr_num = 0;
        req_wdata = 0; req_mask = 0; req_pc = 0; req_vaddr = 0;
        req_ecode = 0; req_esubcode = 0; csr_rdata = 0;
        has_int = 0; int_ecode = 8'h55; ex_entryPC = 0; new_pc = 0;

        step();
        req_valid = 1'b1;
        #1;
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_we", {31'd0, csr_we}, 32'd0);
        chk("rst_re", {31'd0, csr_re}, 32'd0);
        chk("rst_redir", {31'd0, redirect_valid}, 32'd0);
        req_valid = 1'b0;
        step();
        rst = 1'b0;
        #1;

        // CSRRD 0x30
        csr_rdata = 32'hDEADBEEF;
        issue(3'd0, 14'h30, 32'h0, 32'h0);
`ifdef CSR_CMT_FASTRD_EN
        chk("rd_resp_T1", {31'd0, resp_valid}, 32'd1);
        chk("rd_rdata", resp_rdata, 32'hDEADBEEF);
        chk("rd_we_T1", {31'd0, csr_we}, 32'd0);
        step();
`else
        chk("rd_re_T1", {31'd0, csr_re}, 32'd1);
        chk("rd_raddr", {18'd0, csr_raddr}, 32'h30);
        chk("rd_resp_T1", {31'd0, resp_valid}, 32'd0);
        chk("rd_we_T1", {31'd0, csr_we}, 32'd0);
        step();
        chk("rd_resp_T2", {31'd0, resp_valid}, 32'd1);
        chk("rd_rdata", resp_rdata, 32'hDEADBEEF);
        chk("rd_we_T2", {31'd0, csr_we}, 32'd0);
        chk("rd_re_T2", {31'd0, csr_re}, 32'd0);
        step();
`endif
        csr_rdata = 32'h0;
        chk("rd_resp_end", {31'd0, resp_valid}, 32'd0);
        chk("rd_hold", resp_rdata, 32'hDEADBEEF);

        // CSRXCHG 0x04
        csr_rdata = 32'h12345678;
        issue(3'd2, 14'h04, 32'h1FFF, 32'h0800);
        chk("xc_we_T1", {31'd0, csr_we}, 32'd0);
        step();
        chk("xc_we_T2", {31'd0, csr_we}, 32'd1);
        chk("xc_waddr", {18'd0, csr_waddr}, 32'h04);
        chk("xc_wmask", csr_wmask, 32'h0800);
        chk("xc_wdata", csr_wdata, 32'h1FFF);
        chk("xc_resp_T2", {31'd0, resp_valid}, 32'd0);
        step();
        chk("xc_resp_T3", {31'd0, resp_valid}, 32'd1);
        chk("xc_we_T3", {31'd0, csr_we}, 32'd0);
        chk("xc_rdata", resp_rdata, 32'h12345678);
        step();

        // CSRWR full mask
        issue(3'd1, 14'h05, 32'hA5A5_0001, 32'h0000_00FF);
        step();
        chk("wr_we", {31'd0, csr_we}, 32'd1);
        chk("wr_wmask", csr_wmask, 32'hFFFF_FFFF);
        chk("wr_wdata", csr_wdata, 32'hA5A5_0001);
        step();
        chk("wr_resp", {31'd0, resp_valid}, 32'd1);
        step();

        // EXC
        req_ecode = 8'h09; req_esubcode = 1'b1;
        req_vaddr = 32'h1003; req_pc = 32'h1C000100;
        ex_entryPC = 32'h1C008000;
        issue(3'd4, 14'h0, 32'h0, 32'h0);
        chk("ex_en", {31'd0, ex_en}, 32'd1);
        chk("ex_ecode", {24'd0, ecode}, 32'h09);
        chk("ex_esub", {31'd0, esubcode}, 32'd1);
        chk("ex_pc", pc, 32'h1C000100);
        chk("ex_vaddr", vaddr, 32'h1003);
        chk("ex_flush_T1", {31'd0, flush}, 32'd0);
        step();
        chk("ex_en_off", {31'd0, ex_en}, 32'd0);
        chk("ex_pc_off", pc, 32'd0);
        chk("ex_ecode_off", {24'd0, ecode}, 32'd0);
        chk("ex_flush", {31'd0, flush}, 32'd1);
        chk("ex_redir_v", {31'd0, redirect_valid}, 32'd1);
        chk("ex_redir_pc", redirect_pc, 32'h1C008000);
        step();
        chk("ex_flush_end", {31'd0, flush}, 32'd0);
        chk("ex_ready", {31'd0, req_ready}, 32'd1);

        // CSRWR with pending interrupt
        req_ecode = 8'h07; req_esubcode = 1'b1;
        req_pc = 32'h1C000300; has_int = 1'b1;
        ex_entryPC = 32'h1C00A000;
        issue(3'd1, 14'h06, 32'h1, 32'h0);
        has_int = 1'b0;
        chk("int_ex_en", {31'd0, ex_en}, 32'd1);
        chk("int_ecode", {24'd0, ecode}, 32'h00);
        chk("int_esub", {31'd0, esubcode}, 32'd0);
        chk("int_pc", pc, 32'h1C000300);
        chk("int_we_T1", {31'd0, csr_we}, 32'd0);
        step();
        chk("int_we_T2", {31'd0, csr_we}, 32'd0);
        chk("int_flush", {31'd0, flush}, 32'd1);
        chk("int_redir_pc", redirect_pc, 32'h1C00A000);
        step();
        chk("int_resp", {31'd0, resp_valid}, 32'd0);

        // ERTN
        new_pc = 32'h1C000204;
        issue(3'd3, 14'h0, 32'h0, 32'h0);
        chk("ertn_pulse", {31'd0, ertn_flush}, 32'd1);
        chk("ertn_ex_en", {31'd0, ex_en}, 32'd0);
        step();
        chk("ertn_off", {31'd0, ertn_flush}, 32'd0);
        chk("ertn_redir_v", {31'd0, redirect_valid}, 32'd1);
        chk("ertn_redir_pc", redirect_pc, 32'h1C000204);
        step();
        chk("ertn_redir_end", {31'd0, redirect_valid}, 32'd0);

        // Illegal op
        req_ecode = 8'h22; req_esubcode = 1'b1;
        issue(3'd6, 14'h0, 32'h0, 32'h0);
        chk("ine_ex_en", {31'd0, ex_en}, 32'd1);
        chk("ine_ecode", {24'd0, ecode}, 32'h0D);
        chk("ine_esub", {31'd0, esubcode}, 32'd0);
        step();
        step();

        // Reset during WRITE
        issue(3'd1, 14'h07, 32'hCAFE, 32'h0);
        step();
        chk("ab_we_pre", {31'd0, csr_we}, 32'd1);
        rst = 1'b1;
        #1;
        chk("ab_we_drop", {31'd0, csr_we}, 32'd0);
        chk("ab_ready_rst", {31'd0, req_ready}, 32'd0);
        step();
        chk("ab_ready_rst2", {31'd0, req_ready}, 32'd0);
        chk("ab_rdata_rst", resp_rdata, 32'd0);
        rst = 1'b0;
        #1;
        chk("ab_ready_rel", {31'd0, req_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("ab_no_resp", {31'd0, resp_valid}, 32'd0);
            chk("ab_no_we", {31'd0, csr_we}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
